// File: rtl/muldiv_sequencer_if.sv
// Handshake and shared-adder bundle between the CPU controller and the mul/div sequencer.
// The controller side uses the master modport, and the sequencer uses the slave modport.
interface muldiv_sequencer_if #(parameter int WIDTH = 16);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             divzero;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sub;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  modport master (
    output start, op, a, b, add_sum, add_cout,
    input  busy, done, res_lo, res_hi, divzero, add_a, add_b, add_sub
  );

  modport slave (
    input  start, op, a, b, add_sum, add_cout,
    output busy, done, res_lo, res_hi, divzero, add_a, add_b, add_sub
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned shift-add multiply / restoring divide sequencer.
// All arithmetic is done by the shared add/sub unit, which this block drives through the add_* signals.
//   state  | meaning
//   S_IDLE | waiting for start; shared adder is driven quiet
//   S_STEP | one multiply or divide iteration per clock, WIDTH iterations in total
//   S_DONE | one-cycle done pulse; results are valid
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH-1:0] add_a, add_b;
  logic             add_sub;
  logic [WIDTH-1:0] div_t;
  logic             div_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      divzero_q <= divzero_d;
    end
  end

  // In a divide, HI/LO hold the remainder and quotient. This is the partial remainder shifted left with the next dividend bit.
  assign div_t   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign div_ovf = hi_q[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    divzero_d = divzero_q;
    add_a     = '0;
    add_b     = '0;
    add_sub   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          b_d       = bus.b;
          op_d      = bus.op;
          cnt_d     = '0;
          divzero_d = 1'b0;
          if (bus.op && (bus.b == '0)) begin
            lo_d      = '1;
            hi_d      = bus.a;
            divzero_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = bus.a;
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!op_q) begin
          add_a = hi_q;
          add_b = lo_q[0] ? b_q : '0;
          hi_d  = {bus.add_cout, bus.add_sum[WIDTH-1:1]};
          lo_d  = {bus.add_sum[0], lo_q[WIDTH-1:1]};
        end else begin
          add_sub = 1'b1;
          add_a   = div_t;
          add_b   = b_q;
          if (div_ovf || bus.add_cout) begin
            hi_d = bus.add_sum;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_t;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.add_a   = add_a;
  assign bus.add_b   = add_b;
  assign bus.add_sub = add_sub;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.res_lo  = lo_q;
  assign bus.res_hi  = hi_q;
  assign bus.divzero = divzero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table plus hand sequences for reset and ignored starts.
// The bench models the shared adder combinationally, in the same way as the CPU's gate-level unit.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  muldiv_sequencer_if #(.WIDTH(16)) bus ();

  muldiv_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared adder model: A+B, or A+~B+1 with carry meaning no borrow.
  assign {bus.add_cout, bus.add_sum} = bus.add_sub
    ? ({1'b0, bus.add_a} + {1'b0, ~bus.add_b} + 17'd1)
    : ({1'b0, bus.add_a} + {1'b0, bus.add_b});

  typedef struct {
    string       name;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!bus.done && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic launch(input logic op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
  endtask

  task automatic do_op(input vec_t v);
    int n;
    launch(v.op, v.a, v.b);
    chk({v.name, " busy after start"}, 32'(bus.busy), 32'd1);
    chk({v.name, " add_sub in first cycle"}, 32'(bus.add_sub), v.dz ? 32'd0 : 32'(v.op));
    wait_done(40, n);
    chk({v.name, " latency"}, n, v.lat);
    chk({v.name, " res_lo"}, 32'(bus.res_lo), 32'(v.lo));
    chk({v.name, " res_hi"}, 32'(bus.res_hi), 32'(v.hi));
    chk({v.name, " divzero"}, 32'(bus.divzero), 32'(v.dz));
    @(posedge clk); #1;
    chk({v.name, " done single pulse"}, 32'(bus.done), 32'd0);
    chk({v.name, " idle busy"}, 32'(bus.busy), 32'd0);
    chk({v.name, " idle adder quiet"}, {bus.add_a, bus.add_b} | 32'(bus.add_sub), 32'd0);
    chk({v.name, " res held"}, {bus.res_hi, bus.res_lo}, {v.hi, v.lo});
  endtask

  initial begin
    int n;
    int dones;
    vecs[0] = '{"mul 300*200",    1'b0, 16'd300,  16'd200,  16'hEA60, 16'h0000, 1'b0, 16};
    vecs[1] = '{"mul ffff*ffff",  1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 16};
    vecs[2] = '{"mul 8000*2",     1'b0, 16'h8000, 16'd2,    16'h0000, 16'h0001, 1'b0, 16};
    vecs[3] = '{"mul 0*5",        1'b0, 16'd0,    16'd5,    16'h0000, 16'h0000, 1'b0, 16};
    vecs[4] = '{"div 25/7",       1'b1, 16'd25,   16'd7,    16'd3,    16'd4,    1'b0, 16};
    vecs[5] = '{"div ffff/1",     1'b1, 16'hFFFF, 16'd1,    16'hFFFF, 16'h0000, 1'b0, 16};
    vecs[6] = '{"div 1234/0",     1'b1, 16'h1234, 16'd0,    16'hFFFF, 16'h1234, 1'b1, 0};
    vecs[7] = '{"div 5/10",       1'b1, 16'd5,    16'd10,   16'd0,    16'd5,    1'b0, 16};
    vecs[8] = '{"div 100/9",      1'b1, 16'd100,  16'd9,    16'd11,   16'd1,    1'b0, 16};

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    chk("reset outputs", {bus.res_hi, bus.res_lo}, 32'd0);
    chk("reset flags", {29'd0, bus.busy, bus.done, bus.divzero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) do_op(vecs[i]);

    // A second start in the middle of an operation, and one start while done is high, are both ignored.
    launch(1'b0, 16'd300, 16'd200);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 16'd7; bus.b = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    chk("ignored start one done", dones, 1);
    chk("ignored start result", {bus.res_hi, bus.res_lo}, 32'h0000EA60);

    launch(1'b1, 16'd25, 16'd7);
    wait_done(40, n);
    chk("pre-done-start latency", n, 16);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'd9; bus.b = 16'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start in DONE not accepted", 32'(bus.busy), 32'd0);
    chk("start in DONE result held", {bus.res_hi, bus.res_lo}, {16'd4, 16'd3});

    // A reset during iteration 8 aborts the operation and clears the outputs without waiting for a clock edge.
    launch(1'b0, 16'hFFFF, 16'hFFFF);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset busy/done/dz", {29'd0, bus.busy, bus.done, bus.divzero}, 32'd0);
    chk("async reset results", {bus.res_hi, bus.res_lo}, 32'd0);
    chk("async reset adder", {bus.add_a, bus.add_b} | 32'(bus.add_sub), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("no done after abort", dones, 0);
    do_op(vecs[8]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
